// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling default
// and the single parity definition used by both the TX and RX shifters.
package uart_pkg;

    localparam int OSR_DEFAULT = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Expected parity bit for the valid data bits selected by wls (0..3 = 5..8 bits).
    // Sticky parity forces the bit to ~eps; otherwise eps picks even (1) or odd (0).
    function automatic logic parity_calc(input logic [7:0] data,
                                         input logic [1:0] wls,
                                         input logic       eps,
                                         input logic       sp);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - wls);
        x    = ^(data & mask);
        if (sp) begin
            return ~eps;
        end
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// N-flop synchroniser for an asynchronous level input that idles high
// (RX line, CTS, DSR). All stages reset to 1 so reset never looks like a start bit.
module uart_sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Shift the raw input one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    // Synchroniser register chain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// 16550-style UART receive shifter, OSR-times oversampled on baud_pulse.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote over the three ticks around mid-bit (sampling moves one tick later).
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OSR         = OSR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic [1:0] wls,
    input  logic       parity_enable,
    input  logic       even_parity_select,
    input  logic       sticky_parity,
    output logic [7:0] rx_data,
    output logic       push,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [4:0] MID_LOAD = 5'(OSR / 2);
`else
    localparam logic [4:0] MID_LOAD = 5'(OSR / 2 - 1);
`endif
    localparam logic [4:0] BIT_LOAD = 5'(OSR - 1);

    logic rxs;
    logic bit_val;

    rx_state_t  state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q, data_d;
    logic [1:0] wls_q, wls_d;
    logic       pen_q, pen_d;
    logic       eps_q, eps_d;
    logic       sp_q, sp_d;
    logic       par_q, par_d;
    logic       pe_int_q, pe_int_d;
    logic       armed_q, armed_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       push_q, push_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;

    uart_sync_bit #(.N(SYNC_STAGES)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // Keep the two previous tick samples and vote with the current one.
    always_comb begin
        hist_d  = baud_pulse ? {hist_q[0], rxs} : hist_q;
        bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
    end

    // Tick-sample history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign bit_val = rxs;
`endif

    // Next-state and datapath: the frame FSM only moves on baud ticks.
    // NOTE: every _d signal gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        wls_d     = wls_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        sp_d      = sp_q;
        par_d     = par_q;
        pe_int_d  = pe_int_q;
        armed_d   = armed_q;
        rx_data_d = rx_data_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;
        push_d    = 1'b0;

        if (baud_pulse) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (rxs) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = RX_START;
                        count_d = MID_LOAD;
                    end
                end
                RX_START: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else if (bit_val) begin
                        state_d = RX_IDLE;            // glitch, not a start bit
                    end else begin
                        wls_d     = wls;
                        pen_d     = parity_enable;
                        eps_d     = even_parity_select;
                        sp_d      = sticky_parity;
                        data_d    = 8'h00;
                        bit_idx_d = 3'd0;
                        par_d     = 1'b0;
                        pe_int_d  = 1'b0;
                        count_d   = BIT_LOAD;
                        state_d   = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else begin
                        data_d[bit_idx_q] = bit_val;
                        count_d           = BIT_LOAD;
                        if (bit_idx_q == (3'd4 + {1'b0, wls_q})) begin
                            state_d = pen_q ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else begin
                        par_d    = bit_val;
                        pe_int_d = bit_val ^ parity_calc(data_q, wls_q, eps_q, sp_q);
                        count_d  = BIT_LOAD;
                        state_d  = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else begin
                        push_d    = 1'b1;
                        rx_data_d = data_q;
                        pe_d      = pe_int_q;
                        fe_d      = ~bit_val;
                        bi_d      = (data_q == 8'h00) && !(pen_q && par_q) && !bit_val;
                        // A low stop bit disarms start detection until the line idles high.
                        if (!bit_val) begin
                            armed_d = 1'b0;
                        end
                        state_d = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            count_q   <= 5'd0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            wls_q     <= 2'd0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            par_q     <= 1'b0;
            pe_int_q  <= 1'b0;
            armed_q   <= 1'b1;
            rx_data_q <= 8'h00;
            push_q    <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            wls_q     <= wls_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            sp_q      <= sp_d;
            par_q     <= par_d;
            pe_int_q  <= pe_int_d;
            armed_q   <= armed_d;
            rx_data_q <= rx_data_d;
            push_q    <= push_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
        end
    end

    assign rx_data = rx_data_q;
    assign push    = push_q;
    assign pe      = pe_q;
    assign fe      = fe_q;
    assign bi      = bi_q;
    assign busy    = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud_pulse every clk, frames driven bit by bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic       rx;
    logic [1:0] wls;
    logic       parity_enable;
    logic       even_parity_select;
    logic       sticky_parity;
    logic [7:0] rx_data;
    logic       push;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       busy;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int push_cnt  = 0;
    int push_cyc  = 0;
    int start_cyc = 0;
    int p0;

    uart_rx dut (
        .clk                (clk),
        .rst                (rst),
        .baud_pulse         (baud_pulse),
        .rx                 (rx),
        .wls                (wls),
        .parity_enable      (parity_enable),
        .even_parity_select (even_parity_select),
        .sticky_parity      (sticky_parity),
        .rx_data            (rx_data),
        .push               (push),
        .pe                 (pe),
        .fe                 (fe),
        .bi                 (bi),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count push strobes; a strobe wider than one clk counts more than once.
    always @(negedge clk) begin
        if (push === 1'b1) begin
            push_cnt = push_cnt + 1;
            push_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // Start bit, nbits data LSB first, optional parity, one stop bit, two idle bits.
    // wls is rewritten to chg_wls just before data bit chg_bit (-1 = never).
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input logic par, input logic stop,
                              input int chg_bit, input logic [1:0] chg_wls);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) wls = chg_wls;
            send_bit(d[i]);
        end
        if (has_par) send_bit(par);
        send_bit(stop);
        rx = 1'b1;
        repeat (32) @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        baud_pulse         = 1'b1;
        rx                 = 1'b1;
        wls                = 2'd3;
        parity_enable      = 1'b0;
        even_parity_select = 1'b0;
        sticky_parity      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_push", push, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_pe", pe, 0);
        check("rst_fe", fe, 0);
        check("rst_bi", bi, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        // 8N1 0xA5; push 8+128+16+2 = 154 ticks after the start edge
        p0 = push_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, 2'd0);
        check("a5_push_count", push_cnt - p0, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_pe", pe, 0);
        check("a5_fe", fe, 0);
        check("a5_bi", bi, 0);
        check("a5_latency_ok", ((push_cyc - start_cyc - 1) >= 153) && ((push_cyc - start_cyc - 1) <= 155), 1);
        check("a5_busy_after", busy, 0);

        // 5 data bits, even parity: 0x13 has three ones, so the correct parity bit is 1
        wls = 2'd0; parity_enable = 1'b1; even_parity_select = 1'b1;
        p0 = push_cnt;
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, -1, 2'd0);
        check("e5_p0_push_count", push_cnt - p0, 1);
        check("e5_p0_data", rx_data, 8'h13);
        check("e5_p0_pe", pe, 1);
        check("e5_p0_fe", fe, 0);
        send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, -1, 2'd0);
        check("e5_p1_data", rx_data, 8'h13);
        check("e5_p1_pe", pe, 0);

        // 4-tick low glitch: START entered then abandoned, nothing pushed
        wls = 2'd3; parity_enable = 1'b0; even_parity_select = 1'b0;
        p0 = push_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (24) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_low", busy, 0);
        check("glitch_no_push", push_cnt - p0, 0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1, 2'd0);
        check("3c_push_count", push_cnt - p0, 1);
        check("3c_data", rx_data, 8'h3C);
        check("3c_fe", fe, 0);

        // Framing error with non-zero data
        p0 = push_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1, 2'd0);
        check("55_push_count", push_cnt - p0, 1);
        check("55_data", rx_data, 8'h55);
        check("55_fe", fe, 1);
        check("55_bi", bi, 0);

        // Break: line held low for ~3 frame times gives exactly one push
        p0 = push_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (480) @(posedge clk);
        #1;
        check("brk_push_count", push_cnt - p0, 1);
        check("brk_data", rx_data, 8'h00);
        check("brk_fe", fe, 1);
        check("brk_bi", bi, 1);
        check("brk_pe", pe, 0);
        rx = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        check("brk_released_push_count", push_cnt - p0, 1);

        // Sticky parity (expected bit 1), 7 bits, wls changed to 8 bits mid-frame
        wls = 2'd2; parity_enable = 1'b1; sticky_parity = 1'b1; even_parity_select = 1'b0;
        p0 = push_cnt;
        send_frame(8'h2B, 7, 1'b1, 1'b0, 1'b1, 3, 2'd3);
        check("sp7_push_count", push_cnt - p0, 1);
        check("sp7_data", rx_data, 8'h2B);
        check("sp7_pe", pe, 1);
        check("sp7_fe", fe, 0);
        wls = 2'd3; parity_enable = 1'b0; sticky_parity = 1'b0;

        // Reset during the data bits of 0xFF
        p0 = push_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("ff_busy_mid_frame", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ff_rst_push", push, 0);
        check("ff_rst_rx_data", rx_data, 0);
        check("ff_rst_pe", pe, 0);
        check("ff_rst_fe", fe, 0);
        check("ff_rst_bi", bi, 0);
        check("ff_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (160) @(posedge clk);
        #1;
        check("ff_no_push", push_cnt - p0, 0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, 2'd0);
        check("81_push_count", push_cnt - p0, 1);
        check("81_data", rx_data, 8'h81);
        check("81_fe", fe, 0);
        check("81_pe", pe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
